// File: rtl/nr_div_pkg.sv
// nr_div_pkg: shared constants for the non-restoring 16/8 divider.
// Holds the operand width, the iteration count and the FSM state codes.
package nr_div_pkg;

  localparam int W        = 8;
  localparam int ITER_CNT = 8;

  // FSM state codes (kept as plain constants for compatibility with older tools)
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LD_LO  = 3'd1;
  localparam logic [2:0] LD_DIV = 3'd2;
  localparam logic [2:0] ITER   = 3'd3;
  localparam logic [2:0] CORR   = 3'd4;
  localparam logic [2:0] OUT_R  = 3'd5;
  localparam logic [2:0] OUT_Q  = 3'd6;
  localparam logic [2:0] DONE   = 3'd7;

endpackage

// File: rtl/nr_div_addsub.sv
// nr_div_addsub: 9-bit signed add/subtract used by the divider datapath.
// neg=1 adds the divisor (partial remainder was negative), neg=0 subtracts it.
module nr_div_addsub (
  input  logic [8:0] a,
  input  logic [7:0] d,
  input  logic       neg,
  output logic [8:0] y
);

  logic [8:0] d_ext;

  assign d_ext = {1'b0, d};

  // Select add or subtract of the zero-extended divisor
  always_comb begin
    if (neg) begin
      y = a + d_ext;
    end else begin
      y = a - d_ext;
    end
  end

endmodule

// File: rtl/nr_div.sv
// nr_div: sequential non-restoring divider, 16-bit dividend / 8-bit divisor.
// Operands arrive byte-serially on ibus (dividend high, dividend low, divisor);
// results leave on obus (remainder, then quotient) followed by a done flag.
// Optional feature: define NR_DIV_OVF_EN to add divide-overflow detection
// and the ovf output port.
module nr_div #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         bgn,
  input  logic [W-1:0] ibus,
  output logic [W-1:0] obus,
`ifdef NR_DIV_OVF_EN
  output logic         ovf,
`endif
  output logic         stop
);

  import nr_div_pkg::*;

  logic [2:0] state_reg, state_next;
  logic [8:0] a_reg, a_next;     // signed partial remainder; holds dividend high byte while loading
  logic [7:0] q_reg, q_next;     // quotient; holds dividend low byte while loading
  logic [7:0] d_reg, d_next;     // divisor
  logic [2:0] cnt_reg, cnt_next; // iteration counter

  logic [8:0] as_a;
  logic       as_neg;
  logic [8:0] as_y;

`ifdef NR_DIV_OVF_EN
  logic ovf_reg, ovf_next;
  logic ovf_det;

  // Overflow when divisor is zero or the quotient would not fit in 8 bits
  assign ovf_det = (ibus == 8'h00) || (a_reg[7:0] >= ibus);
  assign ovf     = ovf_reg;
`endif

  // Shared adder: in CORR it restores A, in ITER it works on the shifted {A,Q}
  assign as_a   = (state_reg == CORR) ? a_reg : {a_reg[7:0], q_reg[7]};
  assign as_neg = (state_reg == CORR) ? 1'b1 : a_reg[8];

  nr_div_addsub u_addsub (
    .a   (as_a),
    .d   (d_reg),
    .neg (as_neg),
    .y   (as_y)
  );

  // Next-state and datapath update logic
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    q_next     = q_reg;
    d_next     = d_reg;
    cnt_next   = cnt_reg;
`ifdef NR_DIV_OVF_EN
    ovf_next   = ovf_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bgn) begin
          a_next     = {1'b0, ibus};
          state_next = LD_LO;
        end
      end
      LD_LO: begin
        q_next     = ibus;
        state_next = LD_DIV;
      end
      LD_DIV: begin
        d_next     = ibus;
        cnt_next   = 3'd0;
        state_next = ITER;
`ifdef NR_DIV_OVF_EN
        if (ovf_det) begin
          a_next     = 9'h0FF;
          q_next     = 8'hFF;
          ovf_next   = 1'b1;
          state_next = OUT_R;
        end
`endif
      end
      ITER: begin
        a_next   = as_y;
        q_next   = {q_reg[6:0], ~as_y[8]};
        cnt_next = cnt_reg + 3'd1;
        if (cnt_reg == 3'(ITER_CNT - 1)) begin
          state_next = CORR;
        end
      end
      CORR: begin
        if (a_reg[8]) begin
          a_next = as_y;
        end
        state_next = OUT_R;
      end
      OUT_R: begin
        state_next = OUT_Q;
      end
      OUT_Q: begin
        state_next = DONE;
      end
      DONE: begin
        if (!bgn) begin
          state_next = IDLE;
`ifdef NR_DIV_OVF_EN
          ovf_next   = 1'b0;
`endif
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg <= IDLE;
      a_reg     <= 9'd0;
      q_reg     <= 8'd0;
      d_reg     <= 8'd0;
      cnt_reg   <= 3'd0;
`ifdef NR_DIV_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      q_reg     <= q_next;
      d_reg     <= d_next;
      cnt_reg   <= cnt_next;
`ifdef NR_DIV_OVF_EN
      ovf_reg   <= ovf_next;
`endif
    end
  end

  // Output decode: results only in OUT_R/OUT_Q, done flag only in DONE
  always_comb begin
    obus = 8'h00;
    if (state_reg == OUT_R) begin
      obus = a_reg[7:0];
    end else if (state_reg == OUT_Q) begin
      obus = q_reg;
    end
  end

  assign stop = (state_reg == DONE);

endmodule

// File: doc/nr_div.md
NR_DIV -- requirements
Module: nr_div

Interface
REQ-001 Parameter W SHALL default to 8 and set the operand byte width; only W=8 is supported.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_b  input  1  reset, asynchronous, active-low.
REQ-004 bgn  input  1  start request, sampled in IDLE.
REQ-005 ibus  input  8  operand bus: dividend high byte, then dividend low byte, then divisor.
REQ-006 obus  output  8  result bus: remainder, then quotient; 8'h00 when idle.
REQ-007 stop  output  1  done flag, high in DONE only.
REQ-008 ovf  output  1  overflow flag; port present only when NR_DIV_OVF_EN is defined.

Function
REQ-009 The FSM SHALL have the states IDLE, LD_LO, LD_DIV, ITER, CORR, OUT_R, OUT_Q and DONE.
REQ-010 In IDLE with bgn=1 at an edge, the block SHALL capture ibus as dividend[15:8] and go to LD_LO; with bgn=0 it SHALL stay in IDLE.
REQ-011 In LD_LO the block SHALL capture ibus as dividend[7:0] and go to LD_DIV.
REQ-012 In LD_DIV the block SHALL capture ibus as divisor, clear the iteration counter and go to ITER.
REQ-013 ITER SHALL run non-restoring division for exactly 8 cycles, one quotient bit per cycle, on a 9-bit signed partial remainder A and an 8-bit Q.
REQ-014 Each ITER step SHALL shift {A,Q} left by one, then add the divisor if the previous A was negative or subtract it otherwise, with the new Q[0] = ~A_new[8].
REQ-015 CORR SHALL add the divisor to A when A is negative, then go to OUT_R.
REQ-016 OUT_R SHALL drive obus=A[7:0] (remainder) for one cycle, and OUT_Q SHALL drive obus=Q (quotient) for one cycle.
REQ-017 DONE SHALL hold stop=1 and obus=8'h00 until bgn is low at an edge, then return to IDLE.
REQ-018 Latency SHALL be as follows: if edge 1 samples bgn, then remainder is on obus after edge 12, quotient after edge 13, and stop after edge 14.
REQ-019 bgn changes outside IDLE and DONE SHALL be ignored.
REQ-020 Valid inputs SHALL satisfy dividend[15:8] < divisor, giving quotient <= 255, remainder < divisor and dividend = q*divisor + r.
REQ-021 After DONE->IDLE, bgn held high SHALL start a new operation on the next edge, using ibus as the new high byte.

Reset
REQ-022 rst_b=0 SHALL immediately force IDLE, clear A, Q, divisor and counter, and drive obus=8'h00, stop=0 and ovf=0, including mid-operation.
REQ-023 On rst_b release, the first edge SHALL be treated as IDLE.

Configuration
REQ-024 With NR_DIV_OVF_EN defined, LD_DIV SHALL detect divisor==0 or dividend[15:8] >= divisor, skip ITER and CORR, and go to OUT_R with A and Q forced to 8'hFF.
REQ-025 With NR_DIV_OVF_EN defined, ovf SHALL be set on detection, held through DONE, and cleared on entering IDLE.
REQ-026 Without NR_DIV_OVF_EN, no check and no ovf port SHALL exist, and results for invalid inputs are unspecified.

Structure
REQ-027 Package nr_div_pkg SHALL hold the state enumeration, the W constant and the ITER_CNT=8 constant.
REQ-028 Sub-module nr_div_addsub SHALL implement the 9-bit add/subtract selected by a sign input; all other logic SHALL be in nr_div.

Verification
REQ-029 Scenario: ibus 0x12, 0x34, 0x55 (4660/85) -> obus 70 in OUT_R, then 54 in OUT_Q, then stop=1.
REQ-030 Scenario: ibus 0x00, 0xFF, 0x10 -> remainder 15, quotient 15.
REQ-031 Scenario: ibus 0xFE, 0x01, 0xFF (65025/255) -> remainder 0, quotient 255; and 0x7F, 0x00, 0x80 -> remainder 0, quotient 254.
REQ-032 Scenario: rst_b pulsed low in the 4th ITER cycle, then 0x00, 0x09, 0x02 -> obus 0 and stop 0 during reset, then remainder 1, quotient 4.
REQ-033 Scenario (NR_DIV_OVF_EN): 0x20, 0x00, 0x20 and 0x01, 0x00, 0x00 -> obus 0xFF twice, ovf=1 in DONE, ovf=0 after return to IDLE.
REQ-034 Scenario: bgn held high through DONE -> stop stays 1; bgn low -> IDLE on the next edge, with obus 0 and stop 0.
